// File: rtl/keycode_sequencer_pkg.sv
// Shared state encoding and scancode constants for the keycode sequencer.
package keyseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        SAVE,
        WAIT_VAL,
        HOLD
    } state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

endpackage

// File: rtl/keycode_sequencer_if.sv
// Accepted-keycode channel: valid/ready handshake carrying the keycode and its make/break flag.
interface keycode_sequencer_if;

    logic [7:0] Key_Out;
    logic       Key_Release;
    logic       Key_Valid;
    logic       Key_Ready;

    modport master (output Key_Out, Key_Release, Key_Valid, input Key_Ready);
    modport slave  (input Key_Out, Key_Release, Key_Valid, output Key_Ready);

endinterface

// File: rtl/keycode_sequencer.sv
// Turns PS/2 scancode bytes into validated make/break keycodes; Rx_Done to Key_Valid is VAL_LAT+2 cycles.
// Key_Valid holds until Key_Ready; bytes arriving while busy are dropped with Err_Overrun. KEYSEQ_TIMEOUT_EN adds a prefix timeout.
module keycode_sequencer
    import keyseq_pkg::*;
#(
    parameter int VAL_LAT     = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       Clk_S,
    input  logic       Reset_S,
    input  logic [7:0] Rx_Byte,
    input  logic       Rx_Done,
    output logic [7:0] Save_KeyCode,
    output logic       Save_Strobe,
    input  logic [7:0] Valid_KeyCode,
    input  logic       Led_Invalid,
    output logic [7:0] Key_Out,
    output logic       Key_Release,
    output logic       Key_Valid,
    input  logic       Key_Ready,
    output logic       Err_Invalid,
    output logic       Err_Overrun,
    output logic       Err_Timeout
);

    // WAIT_VAL is entered with cnt=0, so the sample edge is at cnt == VAL_LAT-1.
    localparam logic [2:0] SAMPLE_CNT = 3'(VAL_LAT - 1);

    state_t     state, state_nxt;
    logic       brk, brk_nxt;
    logic       ext, ext_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] save_nxt;
    logic [7:0] key_out_nxt;
    logic       key_rel_nxt;
    logic       err_inv_nxt;
    logic       err_ovr_nxt;

`ifdef KEYSEQ_TIMEOUT_EN
    // tmr counts the Rx_Done cycle as 1, so it reaches TIMEOUT_CYC TIMEOUT_CYC cycles after the byte.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmr, tmr_nxt;
    logic        err_tmo_nxt;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign Save_Strobe = (state == SAVE);
    assign Key_Valid   = (state == HOLD);

    always_comb begin
        state_nxt   = state;
        brk_nxt     = brk;
        ext_nxt     = ext;
        cnt_nxt     = cnt;
        save_nxt    = Save_KeyCode;
        key_out_nxt = Key_Out;
        key_rel_nxt = Key_Release;
        err_inv_nxt = 1'b0;
        err_ovr_nxt = 1'b0;
`ifdef KEYSEQ_TIMEOUT_EN
        err_tmo_nxt = 1'b0;
        tmr_nxt     = Rx_Done ? 16'd1 : (state == PREFIX) ? tmr + 16'd1 : tmr;
`endif
        case (state)
            IDLE, PREFIX: begin
                if (Rx_Done) begin
                    if (Rx_Byte == SC_BREAK) begin
                        brk_nxt   = 1'b1;
                        state_nxt = PREFIX;
                    end else if (Rx_Byte == SC_EXT) begin
                        ext_nxt   = 1'b1;
                        state_nxt = PREFIX;
                    end else if (state == PREFIX && ext) begin
                        // Extended keys are not forwarded: swallow the code and forget the prefixes.
                        brk_nxt   = 1'b0;
                        ext_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        save_nxt  = Rx_Byte;
                        state_nxt = SAVE;
                    end
                end
`ifdef KEYSEQ_TIMEOUT_EN
                else if (state == PREFIX && tmr == TMO_LAST) begin
                    brk_nxt     = 1'b0;
                    ext_nxt     = 1'b0;
                    err_tmo_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
`endif
            end
            SAVE: begin
                err_ovr_nxt = Rx_Done;
                cnt_nxt     = 3'd0;
                state_nxt   = WAIT_VAL;
            end
            WAIT_VAL: begin
                err_ovr_nxt = Rx_Done;
                if (cnt == SAMPLE_CNT) begin
                    brk_nxt = 1'b0;
                    ext_nxt = 1'b0;
                    if (Led_Invalid) begin
                        err_inv_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        key_out_nxt = Valid_KeyCode;
                        key_rel_nxt = brk;
                        state_nxt   = HOLD;
                    end
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            HOLD: begin
                err_ovr_nxt = Rx_Done;
                if (Key_Ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_S) begin
        if (!Reset_S) begin
            state        <= IDLE;
            brk          <= 1'b0;
            ext          <= 1'b0;
            cnt          <= 3'd0;
            Save_KeyCode <= 8'h00;
            Key_Out      <= 8'h00;
            Key_Release  <= 1'b0;
            Err_Invalid  <= 1'b0;
            Err_Overrun  <= 1'b0;
        end else begin
            state        <= state_nxt;
            brk          <= brk_nxt;
            ext          <= ext_nxt;
            cnt          <= cnt_nxt;
            Save_KeyCode <= save_nxt;
            Key_Out      <= key_out_nxt;
            Key_Release  <= key_rel_nxt;
            Err_Invalid  <= err_inv_nxt;
            Err_Overrun  <= err_ovr_nxt;
        end
    end

`ifdef KEYSEQ_TIMEOUT_EN
    always_ff @(posedge Clk_S) begin
        if (!Reset_S) begin
            tmr         <= 16'd0;
            Err_Timeout <= 1'b0;
        end else begin
            tmr         <= tmr_nxt;
            Err_Timeout <= err_tmo_nxt;
        end
    end
`else
    assign Err_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keycode_sequencer.sv
// Directed bench for keycode_sequencer with a fixed-latency validator model.
module tb_keycode_sequencer;

    localparam int VAL_LAT = 2;
    localparam int TMO     = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic [7:0] save_code;
    logic       save_stb;
    logic [7:0] val_code;
    logic       led_inv;
    logic       err_inv, err_ovr, err_tmo;

    keycode_sequencer_if kif ();

    keycode_sequencer #(.VAL_LAT(VAL_LAT), .TIMEOUT_CYC(TMO)) dut (
        .Clk_S        (clk),
        .Reset_S      (rst_n),
        .Rx_Byte      (rx_byte),
        .Rx_Done      (rx_done),
        .Save_KeyCode (save_code),
        .Save_Strobe  (save_stb),
        .Valid_KeyCode(val_code),
        .Led_Invalid  (led_inv),
        .Key_Out      (kif.Key_Out),
        .Key_Release  (kif.Key_Release),
        .Key_Valid    (kif.Key_Valid),
        .Key_Ready    (kif.Key_Ready),
        .Err_Invalid  (err_inv),
        .Err_Overrun  (err_ovr),
        .Err_Timeout  (err_tmo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Validator model: answers only at the edge VAL_LAT cycles after the strobe, garbage otherwise.
    logic [7:0] vp_code [VAL_LAT+1];
    logic       vp_vld  [VAL_LAT+1];
    int         val_offset;
    logic       val_reject;

    always @(negedge clk) begin
        for (int i = VAL_LAT; i > 0; i--) begin
            vp_code[i] = vp_code[i-1];
            vp_vld[i]  = vp_vld[i-1];
        end
        vp_code[0] = save_code;
        vp_vld[0]  = save_stb;
        if (vp_vld[VAL_LAT] === 1'b1) begin
            val_code = vp_code[VAL_LAT] + 8'(val_offset);
            led_inv  = val_reject;
        end else begin
            val_code = 8'hAA;
            led_inv  = 1'b1;
        end
    end

    typedef struct {
        int         nb;
        logic [7:0] b0, b1, b2;
        logic       rej;
        int         off;
        int         strobe_at;
        logic [7:0] save;
        int         valid_at;
        logic [7:0] kout;
        logic       krel;
        int         inv_at;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] last_save = 8'h00;

    // Event times are cycles after the cycle carrying the last byte's Rx_Done.
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] bs [3];
        int st = -1, va = -1, iv = -1, vcnt = 0, icnt = 0, ocnt = 0;
        logic [7:0] sv = 8'h00, ko = 8'h00;
        logic kr = 1'b0;
        bs = '{v.b0, v.b1, v.b2};
        val_reject    = v.rej;
        val_offset    = v.off;
        kif.Key_Ready = 1'b1;
        for (int t = 0; t < v.nb + 12; t++) begin
            @(negedge clk);
            if (save_stb === 1'b1 && st < 0) begin st = t - (v.nb - 1); sv = save_code; end
            if (kif.Key_Valid === 1'b1) begin
                if (va < 0) begin va = t - (v.nb - 1); ko = kif.Key_Out; kr = kif.Key_Release; end
                vcnt++;
            end
            if (err_inv === 1'b1) begin if (iv < 0) iv = t - (v.nb - 1); icnt++; end
            if (err_ovr === 1'b1) ocnt++;
            if (t < v.nb) begin rx_byte = bs[t]; rx_done = 1'b1; end
            else rx_done = 1'b0;
        end
        chk({tag, " strobe_at"}, st, v.strobe_at);
        if (v.strobe_at >= 0) begin
            chk({tag, " save_code"}, sv, v.save);
            last_save = v.save;
        end
        chk({tag, " valid_at"}, va, v.valid_at);
        if (v.valid_at >= 0) begin
            chk({tag, " key_out"}, ko, v.kout);
            chk({tag, " key_release"}, kr, v.krel);
        end
        chk({tag, " valid_cycles"}, vcnt, (v.valid_at >= 0) ? 1 : 0);
        chk({tag, " inv_at"}, iv, v.inv_at);
        chk({tag, " inv_cycles"}, icnt, (v.inv_at >= 0) ? 1 : 0);
        chk({tag, " overruns"}, ocnt, 0);
        chk({tag, " save_held"}, save_code, last_save);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " save_code"}, save_code, 0);
        chk({tag, " save_strobe"}, save_stb, 0);
        chk({tag, " key_out"}, kif.Key_Out, 0);
        chk({tag, " key_release"}, kif.Key_Release, 0);
        chk({tag, " key_valid"}, kif.Key_Valid, 0);
        chk({tag, " err_invalid"}, err_inv, 0);
        chk({tag, " err_overrun"}, err_ovr, 0);
        chk({tag, " err_timeout"}, err_tmo, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, first;

        for (int i = 0; i <= VAL_LAT; i++) begin vp_vld[i] = 1'b0; vp_code[i] = 8'h00; end
        rst_n = 1'b0; rx_byte = 8'h00; rx_done = 1'b0; kif.Key_Ready = 1'b0;
        val_offset = 0; val_reject = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        //          nb  b0     b1     b2    rej   off st  save   va  kout   krel  inv
        vecs[0] = '{1, 8'h32, 8'h00, 8'h00, 1'b0, 0,  1, 8'h32,  4, 8'h32, 1'b0, -1};
        vecs[1] = '{2, 8'hF0, 8'h25, 8'h00, 1'b0, 0,  1, 8'h25,  4, 8'h25, 1'b1, -1};
        vecs[2] = '{1, 8'h1C, 8'h00, 8'h00, 1'b1, 0,  1, 8'h1C, -1, 8'h00, 1'b0,  4};
        vecs[3] = '{3, 8'hE0, 8'hF0, 8'h74, 1'b0, 0, -1, 8'h00, -1, 8'h00, 1'b0, -1};
        vecs[4] = '{2, 8'hE0, 8'h75, 8'h00, 1'b0, 0, -1, 8'h00, -1, 8'h00, 1'b0, -1};
        vecs[5] = '{1, 8'h1C, 8'h00, 8'h00, 1'b0, 1,  1, 8'h1C,  4, 8'h1D, 1'b0, -1};
        vecs[6] = '{3, 8'hF0, 8'hF0, 8'h16, 1'b0, 0,  1, 8'h16,  4, 8'h16, 1'b1, -1};
        vecs[7] = '{2, 8'hF0, 8'h5A, 8'h00, 1'b1, 0,  1, 8'h5A, -1, 8'h00, 1'b0,  4};
        vecs[8] = '{1, 8'h5A, 8'h00, 8'h00, 1'b0, 0,  1, 8'h5A,  4, 8'h5A, 1'b0, -1};

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Downstream stalls in HOLD; a byte arriving then is dropped with an overrun pulse.
        val_reject = 1'b0; val_offset = 0; kif.Key_Ready = 1'b0;
        @(negedge clk); rx_byte = 8'h32; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        n = 0;
        while (kif.Key_Valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("hold key_valid", kif.Key_Valid, 1);
        rx_byte = 8'h44; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        chk("hold overrun", err_ovr, 1);
        chk("hold key_valid kept", kif.Key_Valid, 1);
        chk("hold key_out kept", kif.Key_Out, 8'h32);
        @(negedge clk);
        chk("hold overrun one cycle", err_ovr, 0);
        chk("hold save_code kept", save_code, 8'h32);
        kif.Key_Ready = 1'b1;
        @(negedge clk);
        chk("hold released", kif.Key_Valid, 0);
        chk("hold key_out after xfer", kif.Key_Out, 8'h32);

        // Byte arriving in SAVE is dropped; the first key still completes.
        @(negedge clk); rx_byte = 8'h21; rx_done = 1'b1;
        @(negedge clk); rx_byte = 8'h22;
        @(negedge clk); rx_done = 1'b0;
        chk("save overrun", err_ovr, 1);
        n = 0;
        while (kif.Key_Valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("save overrun key_out", kif.Key_Out, 8'h21);
        repeat (3) @(negedge clk);

        // Reset mid-WAIT_VAL, with a byte offered during the reset cycle.
        @(negedge clk); rx_byte = 8'h32; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        @(negedge clk); rst_n = 1'b0; rx_byte = 8'h55; rx_done = 1'b1;
        @(negedge clk); rst_n = 1'b1; rx_done = 1'b0;
        check_all_zero("midreset");
        cnt = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (kif.Key_Valid === 1'b1 || save_stb === 1'b1) cnt++;
        end
        chk("midreset no activity", cnt, 0);
        last_save = 8'h00;

        // Lone break prefix.
        @(negedge clk); rx_byte = 8'hF0; rx_done = 1'b1;
        cnt = 0; first = -1;
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk); rx_done = 1'b0;
            if (err_tmo === 1'b1) begin if (first < 0) first = t; cnt++; end
        end
`ifdef KEYSEQ_TIMEOUT_EN
        chk("timeout at", first, TMO);
        chk("timeout cycles", cnt, 1);
        run_vec('{1, 8'h32, 8'h00, 8'h00, 1'b0, 0, 1, 8'h32, 4, 8'h32, 1'b0, -1}, "post_timeout");
`else
        chk("no timeout pulses", cnt, 0);
        run_vec('{1, 8'h25, 8'h00, 8'h00, 1'b0, 0, 1, 8'h25, 4, 8'h25, 1'b1, -1}, "prefix_waits");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
